// File: rtl/time_entry_loader.sv
// Keypad entry stage for the oven timer: shifts BCD digits into an m:ss image,
// normalises it on start and drives the load pulse and count enable of the counter chain.
module time_entry_loader (
  input  logic       clock,
  input  logic       clr,
  input  logic       key_valid,
  input  logic [3:0] key_data,
  input  logic       start,
  input  logic       cancel,
  input  logic       timer_zero,
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] mins,
  output logic       loadn,
  output logic       count_en,
  output logic [1:0] digits
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ENTRY = 2'd1,
    LOAD  = 2'd2,
    RUN   = 2'd3
  } state_t;

  state_t     state, state_nx;
  logic [3:0] ones_nx, tens_nx, mins_nx;
  logic [1:0] digits_nx;
  logic       first_run, first_run_nx;
  logic       key_digit;
  logic       image_zero;

  assign key_digit  = key_valid && (key_data <= 4'd9);
  assign image_zero = (sec_ones == 4'd0) && (sec_tens == 4'd0) && (mins == 4'd0);

  always_comb begin
    state_nx     = state;
    ones_nx      = sec_ones;
    tens_nx      = sec_tens;
    mins_nx      = mins;
    digits_nx    = digits;
    first_run_nx = first_run;

    case (state)
      IDLE: begin
        if (key_digit) begin
          mins_nx   = sec_tens;
          tens_nx   = sec_ones;
          ones_nx   = key_data;
          digits_nx = 2'd1;
          state_nx  = ENTRY;
        end
      end

      ENTRY: begin
        // start always wins over a coincident digit, even when the image is zero
        if (start) begin
          if (!image_zero) begin
            state_nx = LOAD;
            if (sec_tens > 4'd5) begin
              if (mins < 4'd9) begin
                tens_nx = sec_tens - 4'd6;
                mins_nx = mins + 4'd1;
              end else begin
                mins_nx = 4'd9;
                tens_nx = 4'd5;
                ones_nx = 4'd9;
              end
            end
          end
        end else if (key_digit && (digits < 2'd3)) begin
          mins_nx   = sec_tens;
          tens_nx   = sec_ones;
          ones_nx   = key_data;
          digits_nx = digits + 2'd1;
        end
      end

      LOAD: begin
        state_nx     = RUN;
        first_run_nx = 1'b1;
      end

      RUN: begin
        // the counters have only just loaded on the first RUN cycle, so ignore timer_zero then
        first_run_nx = 1'b0;
        if (timer_zero && !first_run) begin
          state_nx  = IDLE;
          ones_nx   = 4'd0;
          tens_nx   = 4'd0;
          mins_nx   = 4'd0;
          digits_nx = 2'd0;
        end
      end

      default: state_nx = IDLE;
    endcase

    if (cancel) begin
      state_nx     = IDLE;
      ones_nx      = 4'd0;
      tens_nx      = 4'd0;
      mins_nx      = 4'd0;
      digits_nx    = 2'd0;
      first_run_nx = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (clr) begin
      state     <= IDLE;
      sec_ones  <= 4'd0;
      sec_tens  <= 4'd0;
      mins      <= 4'd0;
      digits    <= 2'd0;
      first_run <= 1'b0;
      loadn     <= 1'b1;
      count_en  <= 1'b0;
    end else begin
      state     <= state_nx;
      sec_ones  <= ones_nx;
      sec_tens  <= tens_nx;
      mins      <= mins_nx;
      digits    <= digits_nx;
      first_run <= first_run_nx;
      loadn     <= (state_nx != LOAD);
      count_en  <= (state_nx == RUN);
    end
  end

endmodule

// File: tb/tb_time_entry_loader.sv
// Scenario bench for time_entry_loader: each test queues expected output images
// as it drives a cycle, then pops and compares them once the DUT has updated.
module tb_time_entry_loader;

  logic       clock = 1'b0;
  logic       clr, key_valid, start, cancel, timer_zero;
  logic [3:0] key_data;
  logic [3:0] sec_ones, sec_tens, mins;
  logic       loadn, count_en;
  logic [1:0] digits;

  int checks = 0;
  int passes = 0;

  typedef struct {
    string       name;
    logic [15:0] v;
  } exp_t;

  typedef struct {
    logic        rs;
    logic        kv;
    logic [3:0]  kd;
    logic        st;
    logic        ca;
    logic        tz;
    logic [15:0] v;
    string       name;
  } step_t;

  exp_t sbq[$];

  // {mins, sec_tens, sec_ones, digits, loadn, count_en} with everything cleared
  localparam logic [15:0] ZERO = 16'h0002;

  always #5 clock = ~clock;

  time_entry_loader dut (
    .clock      (clock),
    .clr        (clr),
    .key_valid  (key_valid),
    .key_data   (key_data),
    .start      (start),
    .cancel     (cancel),
    .timer_zero (timer_zero),
    .sec_ones   (sec_ones),
    .sec_tens   (sec_tens),
    .mins       (mins),
    .loadn      (loadn),
    .count_en   (count_en),
    .digits     (digits)
  );

  function automatic logic [15:0] img(input logic [3:0] m, input logic [3:0] t,
                                      input logic [3:0] o, input logic [1:0] d,
                                      input logic ln, input logic ce);
    return {m, t, o, d, ln, ce};
  endfunction

  function automatic logic [15:0] outv();
    return {mins, sec_tens, sec_ones, digits, loadn, count_en};
  endfunction

  function automatic step_t mk(input logic rs, input logic kv, input logic [3:0] kd,
                               input logic st, input logic ca, input logic tz,
                               input logic [15:0] v, input string name);
    step_t s;
    s.rs = rs; s.kv = kv; s.kd = kd; s.st = st; s.ca = ca; s.tz = tz;
    s.v = v; s.name = name;
    return s;
  endfunction

  function automatic step_t key(input logic [3:0] k, input logic [15:0] v, input string name);
    return mk(1'b0, 1'b1, k, 1'b0, 1'b0, 1'b0, v, name);
  endfunction

  function automatic step_t idle(input logic [15:0] v, input string name);
    return mk(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, v, name);
  endfunction

  // drive one cycle of stimulus, record what the DUT must show after the edge
  task automatic apply(input step_t s);
    exp_t e;
    clr        = s.rs;
    key_valid  = s.kv;
    key_data   = s.kd;
    start      = s.st;
    cancel     = s.ca;
    timer_zero = s.tz;
    e.name = s.name;
    e.v    = s.v;
    sbq.push_back(e);
    @(posedge clock);
    #1;
    clr        = 1'b0;
    key_valid  = 1'b0;
    key_data   = 4'd0;
    start      = 1'b0;
    cancel     = 1'b0;
    timer_zero = 1'b0;
  endtask

  task automatic test_reset();
    step_t q[$];
    exp_t  e;
    q.push_back(mk(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, ZERO, "reset_init"));
    q.push_back(key(4'd1, img(4'd0, 4'd0, 4'd1, 2'd1, 1'b1, 1'b0), "reset_key1"));
    q.push_back(key(4'd0, img(4'd0, 4'd1, 4'd0, 2'd2, 1'b1, 1'b0), "reset_key0"));
    q.push_back(mk(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, img(4'd0, 4'd1, 4'd0, 2'd2, 1'b0, 1'b0), "reset_start"));
    q.push_back(idle(img(4'd0, 4'd1, 4'd0, 2'd2, 1'b1, 1'b1), "reset_run1"));
    q.push_back(idle(img(4'd0, 4'd1, 4'd0, 2'd2, 1'b1, 1'b1), "reset_run2"));
    q.push_back(mk(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, ZERO, "reset_midrun"));
    q.push_back(mk(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, ZERO, "reset_hold"));
    q.push_back(idle(ZERO, "reset_after"));
    foreach (q[i]) begin
      apply(q[i]);
      e = sbq.pop_front();
      checks++;
      if (outv() !== e.v) $display("[TB] FAIL %s: got %h want %h", e.name, outv(), e.v);
      else passes++;
    end
  endtask

  task automatic test_shift_entry();
    step_t q[$];
    exp_t  e;
    q.push_back(key(4'd12, ZERO, "shift_idle_code12"));
    q.push_back(key(4'd1, img(4'd0, 4'd0, 4'd1, 2'd1, 1'b1, 1'b0), "shift_key1"));
    q.push_back(key(4'd3, img(4'd0, 4'd1, 4'd3, 2'd2, 1'b1, 1'b0), "shift_key3"));
    q.push_back(key(4'd0, img(4'd1, 4'd3, 4'd0, 2'd3, 1'b1, 1'b0), "shift_key0"));
    q.push_back(key(4'd7, img(4'd1, 4'd3, 4'd0, 2'd3, 1'b1, 1'b0), "shift_fourth_key"));
    q.push_back(key(4'd12, img(4'd1, 4'd3, 4'd0, 2'd3, 1'b1, 1'b0), "shift_code12"));
    q.push_back(mk(1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, ZERO, "shift_cancel"));
    foreach (q[i]) begin
      apply(q[i]);
      e = sbq.pop_front();
      checks++;
      if (outv() !== e.v) $display("[TB] FAIL %s: got %h want %h", e.name, outv(), e.v);
      else passes++;
    end
  endtask

  task automatic test_normalise();
    step_t q[$];
    exp_t  e;
    q.push_back(key(4'd1, img(4'd0, 4'd0, 4'd1, 2'd1, 1'b1, 1'b0), "norm175_k1"));
    q.push_back(key(4'd7, img(4'd0, 4'd1, 4'd7, 2'd2, 1'b1, 1'b0), "norm175_k7"));
    q.push_back(key(4'd5, img(4'd1, 4'd7, 4'd5, 2'd3, 1'b1, 1'b0), "norm175_k5"));
    q.push_back(mk(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, img(4'd2, 4'd1, 4'd5, 2'd3, 1'b0, 1'b0), "norm175_load"));
    q.push_back(idle(img(4'd2, 4'd1, 4'd5, 2'd3, 1'b1, 1'b1), "norm175_run"));
    q.push_back(idle(img(4'd2, 4'd1, 4'd5, 2'd3, 1'b1, 1'b1), "norm175_loadn_once"));
    q.push_back(mk(1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, ZERO, "norm175_cancel"));
    q.push_back(key(4'd9, img(4'd0, 4'd0, 4'd9, 2'd1, 1'b1, 1'b0), "norm999_k1"));
    q.push_back(key(4'd9, img(4'd0, 4'd9, 4'd9, 2'd2, 1'b1, 1'b0), "norm999_k2"));
    q.push_back(key(4'd9, img(4'd9, 4'd9, 4'd9, 2'd3, 1'b1, 1'b0), "norm999_k3"));
    q.push_back(mk(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, img(4'd9, 4'd5, 4'd9, 2'd3, 1'b0, 1'b0), "norm999_load"));
    q.push_back(idle(img(4'd9, 4'd5, 4'd9, 2'd3, 1'b1, 1'b1), "norm999_run"));
    q.push_back(idle(img(4'd9, 4'd5, 4'd9, 2'd3, 1'b1, 1'b1), "norm999_loadn_once"));
    q.push_back(mk(1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, ZERO, "norm999_cancel"));
    foreach (q[i]) begin
      apply(q[i]);
      e = sbq.pop_front();
      checks++;
      if (outv() !== e.v) $display("[TB] FAIL %s: got %h want %h", e.name, outv(), e.v);
      else passes++;
    end
  endtask

  task automatic test_start_guards();
    step_t q[$];
    exp_t  e;
    q.push_back(mk(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, ZERO, "guard_start_idle"));
    q.push_back(idle(ZERO, "guard_idle_after"));
    q.push_back(key(4'd0, img(4'd0, 4'd0, 4'd0, 2'd1, 1'b1, 1'b0), "guard_k0a"));
    q.push_back(key(4'd0, img(4'd0, 4'd0, 4'd0, 2'd2, 1'b1, 1'b0), "guard_k0b"));
    q.push_back(mk(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, img(4'd0, 4'd0, 4'd0, 2'd2, 1'b1, 1'b0), "guard_start_zero"));
    q.push_back(idle(img(4'd0, 4'd0, 4'd0, 2'd2, 1'b1, 1'b0), "guard_no_run"));
    q.push_back(key(4'd5, img(4'd0, 4'd0, 4'd5, 2'd3, 1'b1, 1'b0), "guard_still_entry"));
    q.push_back(mk(1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, ZERO, "guard_cancel"));
    foreach (q[i]) begin
      apply(q[i]);
      e = sbq.pop_front();
      checks++;
      if (outv() !== e.v) $display("[TB] FAIL %s: got %h want %h", e.name, outv(), e.v);
      else passes++;
    end
  endtask

  task automatic test_run_finish();
    step_t q[$];
    exp_t  e;
    logic [15:0] running;
    running = img(4'd0, 4'd4, 4'd5, 2'd2, 1'b1, 1'b1);
    q.push_back(key(4'd4, img(4'd0, 4'd0, 4'd4, 2'd1, 1'b1, 1'b0), "run_k4"));
    q.push_back(key(4'd5, img(4'd0, 4'd4, 4'd5, 2'd2, 1'b1, 1'b0), "run_k5"));
    q.push_back(mk(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, img(4'd0, 4'd4, 4'd5, 2'd2, 1'b0, 1'b0), "run_load"));
    q.push_back(idle(running, "run_enable"));
    for (int i = 0; i < 18; i++) begin
      if (i % 3 == 0) q.push_back(key(4'd8, running, "run_key8_ignored"));
      else            q.push_back(idle(running, "run_hold"));
    end
    q.push_back(mk(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, ZERO, "run_timer_zero"));
    q.push_back(idle(ZERO, "run_back_idle"));
    foreach (q[i]) begin
      apply(q[i]);
      e = sbq.pop_front();
      checks++;
      if (outv() !== e.v) $display("[TB] FAIL %s: got %h want %h", e.name, outv(), e.v);
      else passes++;
    end
  endtask

  task automatic test_first_run_cycle();
    step_t q[$];
    exp_t  e;
    logic [15:0] running;
    running = img(4'd0, 4'd0, 4'd3, 2'd1, 1'b1, 1'b1);
    q.push_back(key(4'd3, img(4'd0, 4'd0, 4'd3, 2'd1, 1'b1, 1'b0), "first_k3"));
    q.push_back(mk(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, img(4'd0, 4'd0, 4'd3, 2'd1, 1'b0, 1'b0), "first_load"));
    q.push_back(mk(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, running, "first_tz_in_load"));
    q.push_back(mk(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, running, "first_tz_suppressed"));
    q.push_back(mk(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, ZERO, "first_tz_taken"));
    foreach (q[i]) begin
      apply(q[i]);
      e = sbq.pop_front();
      checks++;
      if (outv() !== e.v) $display("[TB] FAIL %s: got %h want %h", e.name, outv(), e.v);
      else passes++;
    end
  endtask

  task automatic test_cancel_collision();
    step_t q[$];
    exp_t  e;
    q.push_back(key(4'd2, img(4'd0, 4'd0, 4'd2, 2'd1, 1'b1, 1'b0), "cc_k2"));
    q.push_back(key(4'd3, img(4'd0, 4'd2, 4'd3, 2'd2, 1'b1, 1'b0), "cc_k3"));
    q.push_back(mk(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, img(4'd0, 4'd2, 4'd3, 2'd2, 1'b0, 1'b0), "cc_load"));
    q.push_back(idle(img(4'd0, 4'd2, 4'd3, 2'd2, 1'b1, 1'b1), "cc_run"));
    q.push_back(mk(1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, ZERO, "cc_cancel_run"));
    q.push_back(key(4'd1, img(4'd0, 4'd0, 4'd1, 2'd1, 1'b1, 1'b0), "cc_k1"));
    q.push_back(mk(1'b0, 1'b1, 4'd9, 1'b1, 1'b0, 1'b0, img(4'd0, 4'd0, 4'd1, 2'd1, 1'b0, 1'b0), "cc_start_and_key"));
    q.push_back(idle(img(4'd0, 4'd0, 4'd1, 2'd1, 1'b1, 1'b1), "cc_run2"));
    q.push_back(mk(1'b0, 1'b1, 4'd6, 1'b1, 1'b1, 1'b0, ZERO, "cc_cancel_beats_all"));
    foreach (q[i]) begin
      apply(q[i]);
      e = sbq.pop_front();
      checks++;
      if (outv() !== e.v) $display("[TB] FAIL %s: got %h want %h", e.name, outv(), e.v);
      else passes++;
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    clr        = 1'b1;
    key_valid  = 1'b0;
    key_data   = 4'd0;
    start      = 1'b0;
    cancel     = 1'b0;
    timer_zero = 1'b0;
    #1;
    test_reset();
    test_shift_entry();
    test_normalise();
    test_start_guards();
    test_run_finish();
    test_first_run_cycle();
    test_cancel_collision();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
